dcache_responder: RTL

- Responder end of the core's data-memory port: accepts dcache_addr/re/we/din requests, returns read data, and drives stall.
- Direct-mapped, write-back, write-allocate cache. Storage is register arrays.
- Line size is 4 words (128 bit). The backing-memory side is a single-beat 128-bit valid/ready request with a valid-only response.
- Sits between the pipeline's memory/writeback stages and the main-memory arbiter.

---
 rtl/dcache_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache.
// Serves single-word loads and stores from the core. Misses fetch a 4-word line
// from backing memory, and dirty victims are written back before the refill.
module dcache_responder #(
    parameter  int LINES = 16,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   dcache_addr,
    input  logic          dcache_re,
    input  logic [3:0]    dcache_we,
    input  logic [31:0]   dcache_din,
    output logic [31:0]   dcache_dout,
    output logic          stall,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_rw,
    output logic [27:0]   mem_req_addr,
    output logic [127:0]  mem_req_data,
    input  logic          mem_resp_valid,
    input  logic [127:0]  mem_resp_data
);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {IDLE, WB_REQ, RF_REQ, RF_WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [127:0]         data_q [LINES];
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINES-1:0]     valid_q, dirty_q;

    logic [31:2]          req_addr_q, req_addr_d;
    logic [3:0]           req_we_q, req_we_d;
    logic [31:0]          req_din_q, req_din_d;
    logic [31:0]          dout_q, dout_d;
    logic                 stall_q, stall_d;
    logic                 mreq_valid_q, mreq_valid_d;
    logic                 mreq_rw_q, mreq_rw_d;
    logic [27:0]          mreq_addr_q, mreq_addr_d;
    logic [127:0]         mreq_data_q, mreq_data_d;

    // Array write port, shared by store hits and refill installs
    logic                 arr_we;
    logic [IDX_W-1:0]     arr_idx;
    logic [127:0]         arr_line;
    logic [TAG_W-1:0]     arr_tag;
    logic                 arr_dirty;

    logic [IDX_W-1:0]     in_idx, r_idx;
    logic [TAG_W-1:0]     in_tag, r_tag;
    logic [1:0]           in_word, r_word;
    logic [127:0]         in_line;
    logic                 in_store, in_req, in_hit;
    logic                 unused_addr_bits;

    assign in_idx   = dcache_addr[IDX_W+3:4];
    assign in_tag   = dcache_addr[31:IDX_W+4];
    assign in_word  = dcache_addr[3:2];
    assign in_line  = data_q[in_idx];
    assign in_store = |dcache_we;
    assign in_req   = dcache_re | in_store;
    assign in_hit   = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign r_idx    = req_addr_q[IDX_W+3:4];
    assign r_tag    = req_addr_q[31:IDX_W+4];
    assign r_word   = req_addr_q[3:2];
    assign unused_addr_bits = ^dcache_addr[1:0];

    // Byte-merge a store word into a line
    function automatic logic [127:0] merge(input logic [127:0] line, input logic [1:0] word,
                                           input logic [3:0] we, input logic [31:0] din);
        logic [127:0] l;
        l = line;
        for (int b = 0; b < 4; b++)
            if (we[b]) l[{word, 5'd0} + 7'(b*8) +: 8] = din[b*8 +: 8];
        return l;
    endfunction

    // Next-state, request sequencing and array-write decode
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_din_d    = req_din_q;
        dout_d       = dout_q;
        mreq_valid_d = mreq_valid_q;
        mreq_rw_d    = mreq_rw_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_data_d  = mreq_data_q;
        arr_we       = 1'b0;
        arr_idx      = in_idx;
        arr_line     = in_line;
        arr_tag      = in_tag;
        arr_dirty    = 1'b0;
        unique case (state_q)
            IDLE: if (in_req && !stall_q) begin
                req_addr_d = dcache_addr[31:2];
                req_we_d   = dcache_we;
                req_din_d  = dcache_din;
                if (in_hit) begin
                    // Load (or pre-store word for stores) returned next cycle
                    dout_d = in_line[{in_word, 5'd0} +: 32];
                    if (in_store) begin
                        arr_we    = 1'b1;
                        arr_line  = merge(in_line, in_word, dcache_we, dcache_din);
                        arr_dirty = 1'b1;
                    end
                end else if (valid_q[in_idx] && dirty_q[in_idx]) begin
                    state_d      = WB_REQ;
                    mreq_valid_d = 1'b1;
                    mreq_rw_d    = 1'b1;
                    mreq_addr_d  = {tag_q[in_idx], in_idx};
                    mreq_data_d  = in_line;
                end else begin
                    state_d      = RF_REQ;
                    mreq_valid_d = 1'b1;
                    mreq_rw_d    = 1'b0;
                    mreq_addr_d  = dcache_addr[31:4];
                end
            end
            WB_REQ: if (mem_req_ready) begin
                state_d     = RF_REQ;
                mreq_rw_d   = 1'b0;
                mreq_addr_d = req_addr_q[31:4];
            end
            RF_REQ: if (mem_req_ready) begin
                state_d      = RF_WAIT;
                mreq_valid_d = 1'b0;
            end
            RF_WAIT: if (mem_resp_valid) begin
                state_d   = RESP;
                dout_d    = mem_resp_data[{r_word, 5'd0} +: 32];
                arr_we    = 1'b1;
                arr_idx   = r_idx;
                arr_tag   = r_tag;
                arr_dirty = |req_we_q;
                arr_line  = merge(mem_resp_data, r_word, req_we_q, req_din_q);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE) && (state_d != RESP);
    end

    // Control state, valid/dirty bits and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            stall_q      <= 1'b0;
            dout_q       <= '0;
            mreq_valid_q <= 1'b0;
            mreq_rw_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
            req_addr_q   <= '0;
            req_we_q     <= '0;
            req_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            dout_q       <= dout_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_rw_q    <= mreq_rw_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_data_q  <= mreq_data_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_din_q    <= req_din_d;
            if (arr_we) begin
                valid_q[arr_idx] <= 1'b1;
                dirty_q[arr_idx] <= arr_dirty;
            end
        end
    end

    // Data and tag storage; contents only matter once valid is set
    always_ff @(posedge clk) begin
        if (arr_we && !reset) begin
            data_q[arr_idx] <= arr_line;
            tag_q[arr_idx]  <= arr_tag;
        end
    end

    assign dcache_dout   = dout_q;
    assign stall         = stall_q;
    assign mem_req_valid = mreq_valid_q;
    assign mem_req_rw    = mreq_rw_q;
    assign mem_req_addr  = mreq_addr_q;
    assign mem_req_data  = mreq_data_q;
endmodule
